// File: rtl/factorial_if.sv
// Host-side handshake bundle for the factorial coprocessor.
interface factorial_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned N_W    = 4
);
    logic              start;
    logic              mode;
    logic [N_W-1:0]    n;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] result;
    logic              overflow;

    modport master (
        output start, mode, n,
        input  busy, done, result, overflow
    );

    modport slave (
        input  start, mode, n,
        output busy, done, result, overflow
    );
endinterface

// File: rtl/factorial_engine.sv
// Sequential n! / n!! engine built around an iterative shift-add multiplier.
module factorial_engine #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned N_W    = 4
) (
    input  logic        clock,
    input  logic        reset,
    factorial_if.slave  bus
);
    localparam int unsigned PW    = DATA_W + N_W;
    localparam int unsigned CNT_W = $clog2(N_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        MUL   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    state_t            next_state;

    logic              mode_q;
    logic [N_W-1:0]    k;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] multiplicand;
    logic [N_W-1:0]    multiplier;
    logic [PW-1:0]     product;
    logic [CNT_W-1:0]  bitcnt;
    logic              ovf;
    logic [DATA_W-1:0] result_q;
    logic              overflow_q;
    logic              busy_q;
    logic              done_q;

    logic              k_small;
    logic              last_step;
    logic              accept;
    logic              load;
    logic              finish;
    logic              step;
    logic [N_W-1:0]    mult_shifted;
    logic [PW-1:0]     prod_next;

    assign k_small   = (k <= N_W'(1));
    assign last_step = (bitcnt == CNT_W'(N_W - 1));

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.start) next_state = CHECK;
            CHECK:   next_state = k_small ? DONE : MUL;
            MUL:     if (last_step) next_state = CHECK;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath control strobes decoded from the current state.
    always_comb begin
        accept = 1'b0;
        load   = 1'b0;
        finish = 1'b0;
        step   = 1'b0;
        case (state)
            IDLE:    accept = bus.start;
            CHECK:   begin
                load   = !k_small;
                finish = k_small;
            end
            MUL:     step = 1'b1;
            default: ;
        endcase
    end

    // One shift-add partial product per MUL cycle.
    always_comb begin
        mult_shifted = multiplier >> bitcnt;
        prod_next    = product;
        if (mult_shifted[0]) begin
            prod_next = product + (PW'(multiplicand) << bitcnt);
        end
    end

    // Operand, accumulator and result registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mode_q       <= 1'b0;
            k            <= '0;
            acc          <= '0;
            multiplicand <= '0;
            multiplier   <= '0;
            product      <= '0;
            bitcnt       <= '0;
            ovf          <= 1'b0;
            result_q     <= '0;
            overflow_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            busy_q <= (next_state != IDLE);
            done_q <= (next_state == DONE);
            if (accept) begin
                mode_q <= bus.mode;
                k      <= bus.n;
                acc    <= DATA_W'(1);
                ovf    <= 1'b0;
            end
            if (load) begin
                multiplicand <= acc;
                multiplier   <= k;
                product      <= '0;
                bitcnt       <= '0;
            end
            if (step) begin
                product <= prod_next;
                bitcnt  <= bitcnt + CNT_W'(1);
                if (last_step) begin
                    acc <= prod_next[DATA_W-1:0];
                    ovf <= ovf | (|prod_next[PW-1:DATA_W]);
                    k   <= mode_q ? (k - N_W'(2)) : (k - N_W'(1));
                end
            end
            // Result is captured on entry to DONE so it is valid alongside done.
            if (finish) begin
                result_q   <= acc;
                overflow_q <= ovf;
            end
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_factorial_engine.sv
// Directed bench for factorial_engine: vector table plus handshake corner cases.
module tb_factorial_engine;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned N_W    = 4;
    localparam int          LIMIT  = 300;

    logic clock;
    logic reset;

    factorial_if #(.DATA_W(DATA_W), .N_W(N_W)) bus ();

    factorial_engine #(.DATA_W(DATA_W), .N_W(N_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        mode;
        int          n;
        int          exp_result;
        logic        exp_ovf;
        int          exp_cycle;
    } vec_t;

    int checks;
    int passed;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Advance cycle by cycle until done or the budget runs out.
    task automatic wait_done(input int c_in, output int c_out);
        int c;
        c = c_in;
        while (!bus.done && c < LIMIT) begin
            @(posedge clock); #1;
            c++;
        end
        c_out = c;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int cyc;
        logic [DATA_W-1:0] res;
        @(posedge clock); #1;
        bus.start = 1'b1;
        bus.mode  = v.mode;
        bus.n     = N_W'(v.n);
        cyc = 0;
        @(posedge clock); #1;
        bus.start = 1'b0;
        cyc = 1;
        chk($sformatf("%s busy_at_1", tag), bus.busy, 1);
        wait_done(cyc, cyc);
        chk($sformatf("%s done_cycle", tag), cyc, v.exp_cycle);
        chk($sformatf("%s result", tag), bus.result, v.exp_result);
        chk($sformatf("%s overflow", tag), bus.overflow, v.exp_ovf);
        res = bus.result;
        @(posedge clock); #1;
        chk($sformatf("%s done_single", tag), bus.done, 0);
        chk($sformatf("%s result_hold", tag), bus.result, v.exp_result);
    endtask

    initial begin
        vec_t vecs[12];
        int   cyc;
        logic saw_done;

        checks = 0;
        passed = 0;

        vecs[0]  = '{1'b0, 5,  120,   1'b0, 22};
        vecs[1]  = '{1'b0, 9,  35200, 1'b1, 42};
        vecs[2]  = '{1'b0, 3,  6,     1'b0, 12};
        vecs[3]  = '{1'b1, 7,  105,   1'b0, 17};
        vecs[4]  = '{1'b1, 8,  384,   1'b0, 22};
        vecs[5]  = '{1'b0, 0,  1,     1'b0, 2};
        vecs[6]  = '{1'b0, 1,  1,     1'b0, 2};
        vecs[7]  = '{1'b1, 0,  1,     1'b0, 2};
        vecs[8]  = '{1'b1, 1,  1,     1'b0, 2};
        vecs[9]  = '{1'b0, 15, 22528, 1'b1, 72};
        vecs[10] = '{1'b1, 15, 60945, 1'b1, 37};
        vecs[11] = '{1'b0, 4,  24,    1'b0, 17};

        reset     = 1'b0;
        bus.start = 1'b0;
        bus.mode  = 1'b0;
        bus.n     = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset busy", bus.busy, 0);
        chk("reset done", bus.done, 0);
        chk("reset result", bus.result, 0);
        chk("reset overflow", bus.overflow, 0);
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Start re-pulsed mid-MUL with different operands is ignored.
        @(posedge clock); #1;
        bus.start = 1'b1; bus.mode = 1'b0; bus.n = N_W'(6);
        cyc = 0;
        @(posedge clock); #1;
        bus.start = 1'b0; cyc = 1;
        @(posedge clock); #1; cyc = 2;
        @(posedge clock); #1; cyc = 3;
        bus.start = 1'b1; bus.mode = 1'b1; bus.n = N_W'(2);
        @(posedge clock); #1; cyc = 4;
        bus.start = 1'b0;
        wait_done(cyc, cyc);
        chk("ignore done_cycle", cyc, 27);
        chk("ignore result", bus.result, 720);
        chk("ignore overflow", bus.overflow, 0);
        @(posedge clock); #1;
        chk("ignore no_restart", bus.busy, 0);

        // Start held high gives back-to-back runs.
        @(posedge clock); #1;
        bus.start = 1'b1; bus.mode = 1'b0; bus.n = N_W'(3);
        cyc = 0;
        @(posedge clock); #1; cyc = 1;
        wait_done(cyc, cyc);
        chk("held first_done", cyc, 12);
        chk("held first_result", bus.result, 6);
        @(posedge clock); #1; cyc++;
        chk("held done_single", bus.done, 0);
        wait_done(cyc, cyc);
        chk("held second_done", cyc, 25);
        bus.start = 1'b0;
        @(posedge clock); #1;
        chk("held second_single", bus.done, 0);
        repeat (2) @(posedge clock);
        #1;

        // Asynchronous reset mid-MUL aborts without a done pulse.
        bus.start = 1'b1; bus.mode = 1'b0; bus.n = N_W'(9);
        cyc = 0;
        @(posedge clock); #1; cyc = 1;
        bus.start = 1'b0;
        repeat (3) @(posedge clock);
        #3;
        reset = 1'b0;
        #1;
        chk("abort busy", bus.busy, 0);
        chk("abort done", bus.done, 0);
        chk("abort result", bus.result, 0);
        chk("abort overflow", bus.overflow, 0);
        saw_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (bus.done) saw_done = 1'b1;
        end
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (bus.done) saw_done = 1'b1;
        end
        chk("abort no_done", saw_done, 0);
        run_vec(vecs[11], "post_reset");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
